// File: rtl/skinny_sbox8_cms1_pipelined_lanes_pkg.sv
// Shared types, constants and the unmasked reference S-box for the CMS first-order
// SKINNY-128 8-bit S-box array.
package skinny_cms1_pkg;

    localparam int unsigned SBOX_LAT    = 4;
    localparam int unsigned RW_PER_SBOX = 32;

    // Pipeline stage (1..4) of gadget gi, element i.
    localparam logic [7:0][2:0] GADGET_STAGE = {
        3'd4, 3'd3, 3'd3, 3'd2, 3'd2, 3'd1, 3'd1, 3'd1
    };

    // Output bit position of compressed value ai, element i.
    localparam logic [7:0][2:0] OUT_BIT = {
        3'd0, 3'd4, 3'd1, 3'd3, 3'd7, 3'd2, 3'd5, 3'd6
    };

    // Two-share bit: [1] = share 1, [0] = share 0.
    typedef logic [1:0] share2_t;

    typedef struct packed {
        share2_t b1;
        share2_t b2;
        share2_t b3;
        share2_t b5;
        share2_t b7;
    } fwd1_t;

    typedef struct packed {
        share2_t a0;
        share2_t a1;
        share2_t a2;
        share2_t b2;
        share2_t b3;
        share2_t b7;
    } fwd2_t;

    typedef struct packed {
        share2_t a0;
        share2_t a1;
        share2_t a2;
        share2_t a3;
        share2_t a4;
        share2_t b2;
    } fwd3_t;

    typedef struct packed {
        share2_t a0;
        share2_t a1;
        share2_t a2;
        share2_t a3;
        share2_t a4;
        share2_t a5;
        share2_t a6;
    } fwd4_t;

    // Unmasked S8 as four NOR-XOR rounds with the inter-round bit permutation.
    function automatic logic [7:0] s8(input logic [7:0] x_in);
        logic [7:0] x;
        x = x_in;
        for (int rnd = 0; rnd < 4; rnd++) begin
            x[4] = x[4] ^ ~(x[7] | x[6]);
            x[0] = x[0] ^ ~(x[3] | x[2]);
            if (rnd < 3) begin
                x = {x[2], x[1], x[7], x[6], x[4], x[0], x[3], x[5]};
            end else begin
                x = {x[7:3], x[1], x[2], x[0]};
            end
        end
        return x;
    endfunction

endpackage

// File: rtl/skinny_sbox8_cms1_pipelined_lanes_if.sv
// Valid/ready stream bundle carrying the input shares, fresh masks and output shares.
interface skinny_sbox8_cms1_pipelined_lanes_if #(
    parameter int unsigned LANES = 4,
    parameter int unsigned RW    = 32
) ();
    import skinny_cms1_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [8*LANES-1:0]    si0;
    logic [8*LANES-1:0]    si1;
    logic [RW*LANES-1:0]   r;
    logic                  out_valid;
    logic                  out_ready;
    logic [8*LANES-1:0]    bo0;
    logic [8*LANES-1:0]    bo1;

    modport master (
        output in_valid,
        output si0,
        output si1,
        output r,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  bo0,
        input  bo1
    );

    modport slave (
        input  in_valid,
        input  si0,
        input  si1,
        input  r,
        input  out_ready,
        output in_ready,
        output out_valid,
        output bo0,
        output bo1
    );

endinterface

// File: rtl/skinny_sbox8_cms1_pipelined_lanes_gadget.sv
// One CMS gadget computing (~a & ~b) ^ z on two shares; partial products and z are
// registered, compression happens combinationally after the register.
module cms1_nor_xor_gadget
    import skinny_cms1_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  share2_t    a,
    input  share2_t    b,
    input  share2_t    z,
    input  logic [3:0] r,
    output share2_t    f
);
    logic       x0, x1, y0, y1;
    logic [3:0] p_d, p_q;
    share2_t    zd_q;

    // Complementing share 0 alone negates the shared value.
    always_comb begin
        x0     = ~a[0];
        x1     = a[1];
        y0     = ~b[0];
        y1     = b[1];
        p_d    = '0;
        p_d[0] = (x0 & y0) ^ r[0] ^ r[1];
        p_d[1] = (x0 & y1) ^ r[1] ^ r[2];
        p_d[2] = (x1 & y0) ^ r[2] ^ r[3];
        p_d[3] = (x1 & y1) ^ r[3] ^ r[0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_q  <= '0;
            zd_q <= '0;
        end else if (en) begin
            p_q  <= p_d;
            zd_q <= z;
        end
    end

    assign f = {p_q[2] ^ p_q[3] ^ zd_q[1], p_q[0] ^ p_q[1] ^ zd_q[0]};

endmodule

// File: rtl/skinny_sbox8_cms1_pipelined_lanes.sv
// LANES parallel 4-stage masked SKINNY-128 S-boxes behind a single global stall enable.
module skinny_sbox8_cms1_pipelined_lanes
    import skinny_cms1_pkg::*;
#(
    parameter int unsigned LANES = 4,
    parameter int unsigned RW    = 32
) (
    input logic clk,
    input logic rst_n,
    skinny_sbox8_cms1_pipelined_lanes_if.slave bus
);
    logic [SBOX_LAT-1:0] v_q;
    logic                en;
    logic [8*LANES-1:0]  bo0_w;
    logic [8*LANES-1:0]  bo1_w;
    logic [RW*LANES-1:0] r_all;

    // The whole array advances together; only a held output can stall it.
    assign en            = ~v_q[SBOX_LAT-1] | bus.out_ready;
    assign bus.in_ready  = en;
    assign bus.out_valid = v_q[SBOX_LAT-1];
    assign bus.bo0       = bo0_w;
    assign bus.bo1       = bo1_w;
    assign r_all         = bus.r;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q <= '0;
        end else if (en) begin
            v_q <= {v_q[SBOX_LAT-2:0], bus.in_valid};
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        share2_t       in_b  [8];
        share2_t       a     [8];
        share2_t       out_a [8];
        logic [RW-1:0] rl;
        fwd1_t         f1_d, f1_q;
        fwd2_t         f2_d, f2_q;
        fwd3_t         f3_d, f3_q;
        fwd4_t         f4_d, f4_q;

        assign rl = r_all[RW*k +: RW];

        for (genvar i = 0; i < 8; i++) begin : g_in
            assign in_b[i] = {bus.si1[8*k+i], bus.si0[8*k+i]};
        end

        // Stage 1
        cms1_nor_xor_gadget u_g0 (
            .clk(clk), .rst_n(rst_n), .en(en),
            .a(in_b[7]), .b(in_b[6]), .z(in_b[4]), .r(rl[3:0]), .f(a[0])
        );
        cms1_nor_xor_gadget u_g1 (
            .clk(clk), .rst_n(rst_n), .en(en),
            .a(in_b[3]), .b(in_b[2]), .z(in_b[0]), .r(rl[7:4]), .f(a[1])
        );
        cms1_nor_xor_gadget u_g2 (
            .clk(clk), .rst_n(rst_n), .en(en),
            .a(in_b[2]), .b(in_b[1]), .z(in_b[6]), .r(rl[11:8]), .f(a[2])
        );

        // Stage 2
        cms1_nor_xor_gadget u_g3 (
            .clk(clk), .rst_n(rst_n), .en(en),
            .a(a[0]), .b(a[1]), .z(f1_q.b5), .r(rl[15:12]), .f(a[3])
        );
        cms1_nor_xor_gadget u_g4 (
            .clk(clk), .rst_n(rst_n), .en(en),
            .a(a[1]), .b(f1_q.b3), .z(f1_q.b1), .r(rl[19:16]), .f(a[4])
        );

        // Stage 3
        cms1_nor_xor_gadget u_g5 (
            .clk(clk), .rst_n(rst_n), .en(en),
            .a(f2_q.a2), .b(a[3]), .z(f2_q.b7), .r(rl[23:20]), .f(a[5])
        );
        cms1_nor_xor_gadget u_g6 (
            .clk(clk), .rst_n(rst_n), .en(en),
            .a(a[3]), .b(f2_q.a0), .z(f2_q.b3), .r(rl[27:24]), .f(a[6])
        );

        // Stage 4
        cms1_nor_xor_gadget u_g7 (
            .clk(clk), .rst_n(rst_n), .en(en),
            .a(f3_q.a4), .b(a[5]), .z(f3_q.b2), .r(rl[31:28]), .f(a[7])
        );

        always_comb begin
            f1_d    = '0;
            f1_d.b1 = in_b[1];
            f1_d.b2 = in_b[2];
            f1_d.b3 = in_b[3];
            f1_d.b5 = in_b[5];
            f1_d.b7 = in_b[7];

            f2_d    = '0;
            f2_d.a0 = a[0];
            f2_d.a1 = a[1];
            f2_d.a2 = a[2];
            f2_d.b2 = f1_q.b2;
            f2_d.b3 = f1_q.b3;
            f2_d.b7 = f1_q.b7;

            f3_d    = '0;
            f3_d.a0 = f2_q.a0;
            f3_d.a1 = f2_q.a1;
            f3_d.a2 = f2_q.a2;
            f3_d.a3 = a[3];
            f3_d.a4 = a[4];
            f3_d.b2 = f2_q.b2;

            f4_d    = '0;
            f4_d.a0 = f3_q.a0;
            f4_d.a1 = f3_q.a1;
            f4_d.a2 = f3_q.a2;
            f4_d.a3 = f3_q.a3;
            f4_d.a4 = f3_q.a4;
            f4_d.a5 = a[5];
            f4_d.a6 = a[6];
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                f1_q <= '0;
                f2_q <= '0;
                f3_q <= '0;
                f4_q <= '0;
            end else if (en) begin
                f1_q <= f1_d;
                f2_q <= f2_d;
                f3_q <= f3_d;
                f4_q <= f4_d;
            end
        end

        assign out_a[0] = f4_q.a0;
        assign out_a[1] = f4_q.a1;
        assign out_a[2] = f4_q.a2;
        assign out_a[3] = f4_q.a3;
        assign out_a[4] = f4_q.a4;
        assign out_a[5] = f4_q.a5;
        assign out_a[6] = f4_q.a6;
        assign out_a[7] = a[7];

        for (genvar i = 0; i < 8; i++) begin : g_out
            localparam int Pos = 8 * k + int'(OUT_BIT[i]);
            assign bo0_w[Pos] = out_a[i][0];
            assign bo1_w[Pos] = out_a[i][1];
        end
    end

endmodule
